distance_accumulator: RTL and testbench
=======================================

Name: distance_accumulator

Overview:
- Downstream neighbour of the per-coefficient squared-difference stage.
- Consumes one 64-bit squared difference per handshake and sums VEC_LEN of them into the squared Euclidean distance for one template.
- Repeats this for NUM_TEMPLATES templates, keeping the running minimum.
- Presents the best distance and its template index to the classifier, holding them until acknowledged.

Parameters:
- DATA_W, 64, width of incoming squared-difference word.
- VEC_LEN, 13, coefficients per feature vector (MFCC count); must be ≥1.
- NUM_TEMPLATES, 8, templates compared per utterance frame; must be ≥1.
- ACC_W, DATA_W+$clog2(VEC_LEN+1), accumulator/result width. Derived; no overflow possible.
- IDX_W, max(1,$clog2(NUM_TEMPLATES)), template index width. Derived.

Ports:
- iclk  in  1  single clock; all logic on its rising edge.
- irst  in  1  synchronous, active-high reset.
- idata  in  DATA_W  squared difference from upstream; valid while ivalid=1.
- ivalid  in  1  upstream data valid (level; held until acked).
- oack  out  1  acknowledge to upstream; level, see handshake rules.
- odist  out  ACC_W  minimum squared distance over all templates.
- oindex  out  IDX_W  template index of odist.
- ovalid  out  1  result valid; held until iack.
- iack  in  1  downstream acknowledge of result.
- obusy  out  1  high whenever state ≠ ACCUM or any partial sum/template count is nonzero.

Behaviour:
Reset (irst=1 at a clock edge):
- State ACCUM; acc, best, best_idx, elem_cnt, tmpl_cnt, ack_flag = 0.
- Outputs oack=0, ovalid=0, odist=0, oindex=0, obusy=0.
- Reset mid-operation discards partial sums with no output.

Input handshake:
- Capture occurs when state=ACCUM, ivalid=1 and ack_flag=0: acc <= acc + zero-extended idata, elem_cnt++, ack_flag <= 1.
- oack = ack_flag. It stays high until ivalid is sampled 0, then ack_flag <= 0 on that edge.
- Each upstream word is therefore captured exactly once, however long ivalid is held.
- No capture occurs in CMP or RESULT. A word arriving then waits, because ivalid is level and is held upstream.

States:
- ACCUM: on capture with elem_cnt==VEC_LEN-1, go to CMP next cycle; the acc value includes that final element.
- CMP (1 cycle):
  - If tmpl_cnt==0 or acc < best (unsigned, strict), then best <= acc and best_idx <= tmpl_cnt. Ties keep the earlier index.
  - acc <= 0, elem_cnt <= 0.
  - If tmpl_cnt==NUM_TEMPLATES-1, go to RESULT; otherwise tmpl_cnt++ and go to ACCUM.
- RESULT: ovalid=1, odist=best, oindex=best_idx, all stable.
  - When iack is sampled 1: ovalid <= 0, tmpl_cnt <= 0, state <= ACCUM. The next capture is possible on the following edge.
  - iack is ignored outside RESULT.
- odist/oindex keep their last values after ovalid drops, until the next RESULT.

Latency and rules:
- Latency: final element of last template captured at edge t → best updated at t+1 → ovalid=1 after edge t+2.
- VEC_LEN=1: every capture goes straight to CMP.
- NUM_TEMPLATES=1: RESULT follows the first CMP.
- Counters never wrap. elem_cnt and tmpl_cnt are cleared explicitly at terminal counts.
- Simultaneous ivalid falling and a state transition: ack_flag still clears normally; it is independent of state.

Decomposition:
- Shared package distance_pkg holds:
  - state enum {ACCUM, CMP, RESULT};
  - the ACC_W/IDX_W width helper functions;
  - a DIST_DATA_W=64 constant shared with the squared-difference stage.
- No sub-module; the min tracker is a few registers inline.

Test Plan:
- Single template, VEC_LEN=3, NUM_TEMPLATES=1; feed 4, 9, 16 with ivalid held 3 cycles each → each word captured once, oack high until ivalid low; odist=29, oindex=0, ovalid 2 cycles after last capture, held until iack.
- NUM_TEMPLATES=3, VEC_LEN=2; sums 50, 20, 35 → odist=20, oindex=1; after iack, ovalid=0 next cycle and state ACCUM.
- Tie: sums 20, 20, 30 → oindex=0 (earlier kept).
- Max values: VEC_LEN=13, all idata=2^64-1 → odist=13*(2^64-1) exactly in ACC_W=68 bits, no wrap.
- Backpressure: present next utterance word during RESULT with iack withheld 10 cycles → oack stays 0, no capture; after iack, word captured and accumulated normally.
- irst asserted after 2 of 3 elements of template 1 → all outputs 0 next cycle; restarting with a fresh set yields correct results, unaffected by the discarded partial sum.

Source files
------------

// File: rtl/distance_pkg.sv
// Shared definitions for the distance accumulator and its upstream
// squared-difference stage: FSM state encoding and derived-width helpers.
package distance_pkg;

    // Width of the squared-difference word exchanged between the two stages.
    localparam int DIST_DATA_W = 64;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        CMP    = 2'd1,
        RESULT = 2'd2
    } dist_state_e;

    // Accumulator width that can hold vec_len full-scale words without wrapping.
    function automatic int acc_width(input int data_w, input int vec_len);
        return data_w + $clog2(vec_len + 1);
    endfunction

    // Template index width, never narrower than one bit.
    function automatic int idx_width(input int num_templates);
        return (num_templates <= 1) ? 1 : $clog2(num_templates);
    endfunction

endpackage

// File: rtl/distance_accumulator.sv
// Sums VEC_LEN squared differences per template, tracks the minimum sum over
// NUM_TEMPLATES templates and presents the winner until acknowledged.
module distance_accumulator
    import distance_pkg::*;
#(
    parameter int DATA_W        = DIST_DATA_W,
    parameter int VEC_LEN       = 13,
    parameter int NUM_TEMPLATES = 8,
    parameter int ACC_W         = acc_width(DATA_W, VEC_LEN),
    parameter int IDX_W         = idx_width(NUM_TEMPLATES)
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [DATA_W-1:0] idata,
    input  logic              ivalid,
    output logic              oack,
    output logic [ACC_W-1:0]  odist,
    output logic [IDX_W-1:0]  oindex,
    output logic              ovalid,
    input  logic              iack,
    output logic              obusy
);

    // Element counter reaches VEC_LEN for one cycle before CMP clears it.
    localparam int ELEM_W = $clog2(VEC_LEN + 1);
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(VEC_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_TMPL = IDX_W'(NUM_TEMPLATES - 1);

    dist_state_e        state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   best_q;
    logic [IDX_W-1:0]   best_idx_q;
    logic [ELEM_W-1:0]  elem_cnt_q;
    logic [IDX_W-1:0]   tmpl_cnt_q;
    logic               ack_flag_q;
    logic               ovalid_q;
    logic [ACC_W-1:0]   odist_q;
    logic [IDX_W-1:0]   oindex_q;

    logic               capture;
    logic [ACC_W-1:0]   acc_d;
    logic               new_best;

    // A word is taken once per ivalid assertion, and only while accumulating.
    always_comb begin
        capture  = (state_q == ACCUM) && ivalid && !ack_flag_q;
        acc_d    = acc_q + ACC_W'(idata);
        new_best = (tmpl_cnt_q == '0) || (acc_q < best_q);
    end

    // Control FSM, accumulator, minimum tracker and registered result outputs.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            elem_cnt_q <= '0;
            tmpl_cnt_q <= '0;
            ack_flag_q <= 1'b0;
            ovalid_q   <= 1'b0;
            odist_q    <= '0;
            oindex_q   <= '0;
        end else begin
            // The acknowledge follows the upstream level regardless of state.
            if (capture) begin
                ack_flag_q <= 1'b1;
            end else if (!ivalid) begin
                ack_flag_q <= 1'b0;
            end

            case (state_q)
                ACCUM: begin
                    if (capture) begin
                        acc_q      <= acc_d;
                        elem_cnt_q <= elem_cnt_q + ELEM_W'(1);
                        if (elem_cnt_q == LAST_ELEM) begin
                            state_q <= CMP;
                        end
                    end
                end
                CMP: begin
                    // Strict compare: on a tie the earlier template keeps the slot.
                    if (new_best) begin
                        best_q     <= acc_q;
                        best_idx_q <= tmpl_cnt_q;
                    end
                    acc_q      <= '0;
                    elem_cnt_q <= '0;
                    if (tmpl_cnt_q == LAST_TMPL) begin
                        state_q <= RESULT;
                    end else begin
                        tmpl_cnt_q <= tmpl_cnt_q + IDX_W'(1);
                        state_q    <= ACCUM;
                    end
                end
                RESULT: begin
                    // An acknowledge only counts once the result is visible.
                    if (ovalid_q && iack) begin
                        ovalid_q   <= 1'b0;
                        tmpl_cnt_q <= '0;
                        state_q    <= ACCUM;
                    end else begin
                        ovalid_q <= 1'b1;
                        odist_q  <= best_q;
                        oindex_q <= best_idx_q;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    // Busy covers any in-flight work, including a partially summed template.
    always_comb begin
        obusy = (state_q != ACCUM) || (acc_q != '0) ||
                (elem_cnt_q != '0) || (tmpl_cnt_q != '0);
    end

    assign oack   = ack_flag_q;
    assign ovalid = ovalid_q;
    assign odist  = odist_q;
    assign oindex = oindex_q;

endmodule

// File: tb/tb_distance_accumulator.sv
// Directed bench for distance_accumulator: three instances with different
// VEC_LEN/NUM_TEMPLATES, a vector table plus hand-written corner sequences.
module tb_distance_accumulator;

    localparam logic [63:0] MAXW = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int NV = 8;

    logic        iclk;
    logic        irst_a   [3];
    logic [63:0] idata_a  [3];
    logic        ivalid_a [3];
    logic        iack_a   [3];
    logic        oack_a   [3];
    logic        ovalid_a [3];
    logic        obusy_a  [3];
    logic [67:0] odist_a  [3];
    logic [1:0]  oindex_a [3];

    logic [65:0] odist0, odist1;
    logic [67:0] odist2;
    logic [0:0]  oidx0, oidx2;
    logic [1:0]  oidx1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          inst;
        int          n;
        logic [63:0] w [13];
        logic [67:0] exp_dist;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t vecs [NV];

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    distance_accumulator #(.VEC_LEN(3), .NUM_TEMPLATES(1)) u0 (
        .iclk(iclk), .irst(irst_a[0]), .idata(idata_a[0]), .ivalid(ivalid_a[0]),
        .oack(oack_a[0]), .odist(odist0), .oindex(oidx0), .ovalid(ovalid_a[0]),
        .iack(iack_a[0]), .obusy(obusy_a[0])
    );
    distance_accumulator #(.VEC_LEN(2), .NUM_TEMPLATES(3)) u1 (
        .iclk(iclk), .irst(irst_a[1]), .idata(idata_a[1]), .ivalid(ivalid_a[1]),
        .oack(oack_a[1]), .odist(odist1), .oindex(oidx1), .ovalid(ovalid_a[1]),
        .iack(iack_a[1]), .obusy(obusy_a[1])
    );
    distance_accumulator #(.VEC_LEN(13), .NUM_TEMPLATES(1)) u2 (
        .iclk(iclk), .irst(irst_a[2]), .idata(idata_a[2]), .ivalid(ivalid_a[2]),
        .oack(oack_a[2]), .odist(odist2), .oindex(oidx2), .ovalid(ovalid_a[2]),
        .iack(iack_a[2]), .obusy(obusy_a[2])
    );

    always_comb begin
        odist_a[0]  = 68'(odist0);
        odist_a[1]  = 68'(odist1);
        odist_a[2]  = odist2;
        oindex_a[0] = 2'(oidx0);
        oindex_a[1] = oidx1;
        oindex_a[2] = 2'(oidx2);
    end

    task automatic chk(input string name, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one word, hold ivalid for 'hold' cycles, then drop it.
    // vcyc returns the first hold cycle (1-based) at which ovalid was seen.
    task automatic send_word(input int k, input logic [63:0] d, input int hold, output int vcyc);
        idata_a[k]  = d;
        ivalid_a[k] = 1'b1;
        vcyc = -1;
        for (int c = 1; c <= hold; c++) begin
            @(negedge iclk);
            chk($sformatf("oack_high_i%0d", k), 68'(oack_a[k]), 68'd1);
            if (vcyc < 0 && ovalid_a[k]) vcyc = c;
        end
        ivalid_a[k] = 1'b0;
        @(negedge iclk);
        chk($sformatf("oack_low_i%0d", k), 68'(oack_a[k]), 68'd0);
    endtask

    // Wait (bounded) for the result, check it, hold it, then acknowledge.
    task automatic finish_result(input int k, input logic [67:0] ed, input logic [1:0] ei, input string tag);
        int n;
        n = 0;
        while (!ovalid_a[k] && n < 40) begin
            @(negedge iclk);
            n++;
        end
        chk({tag, "_valid"}, 68'(ovalid_a[k]), 68'd1);
        chk({tag, "_dist"}, odist_a[k], ed);
        chk({tag, "_idx"}, 68'(oindex_a[k]), 68'(ei));
        $display("result inst=%0d dist=%0h idx=%0d tag=%s", k, odist_a[k], oindex_a[k], tag);
        repeat (3) @(negedge iclk);
        chk({tag, "_valid_held"}, 68'(ovalid_a[k]), 68'd1);
        chk({tag, "_dist_held"}, odist_a[k], ed);
        iack_a[k] = 1'b1;
        @(negedge iclk);
        iack_a[k] = 1'b0;
        chk({tag, "_valid_drop"}, 68'(ovalid_a[k]), 68'd0);
        chk({tag, "_idle"}, 68'(obusy_a[k]), 68'd0);
        chk({tag, "_dist_kept"}, odist_a[k], ed);
    endtask

    initial begin
        int k, vc, cnt_ack, cnt_val;

        vecs[0] = '{inst: 1, n: 6, w: '{30, 20, 5, 15, 35, 0, 0, 0, 0, 0, 0, 0, 0}, exp_dist: 68'd20, exp_idx: 2'd1};
        vecs[1] = '{inst: 1, n: 6, w: '{10, 10, 15, 5, 30, 0, 0, 0, 0, 0, 0, 0, 0}, exp_dist: 68'd20, exp_idx: 2'd0};
        vecs[2] = '{inst: 1, n: 6, w: '{7, 8, 100, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0}, exp_dist: 68'd5, exp_idx: 2'd2};
        vecs[3] = '{inst: 1, n: 6, w: '{0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0}, exp_dist: 68'd0, exp_idx: 2'd0};
        vecs[4] = '{inst: 0, n: 3, w: '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, exp_dist: 68'd6, exp_idx: 2'd0};
        vecs[5] = '{inst: 2, n: 13, w: '{MAXW, MAXW, MAXW, MAXW, MAXW, MAXW, MAXW, MAXW, MAXW, MAXW, MAXW, MAXW, MAXW},
                    exp_dist: 68'hC_FFFF_FFFF_FFFF_FFF3, exp_idx: 2'd0};
        vecs[6] = '{inst: 1, n: 6, w: '{MAXW, MAXW, 1, 0, MAXW, 1, 0, 0, 0, 0, 0, 0, 0}, exp_dist: 68'd1, exp_idx: 2'd1};
        vecs[7] = '{inst: 2, n: 13, w: '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13}, exp_dist: 68'd91, exp_idx: 2'd0};

        for (int i = 0; i < 3; i++) begin
            irst_a[i] = 1'b1; idata_a[i] = '0; ivalid_a[i] = 1'b0; iack_a[i] = 1'b0;
        end
        repeat (2) @(negedge iclk);
        for (int i = 0; i < 3; i++) irst_a[i] = 1'b0;
        @(negedge iclk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ovalid_i%0d", i), 68'(ovalid_a[i]), 68'd0);
            chk($sformatf("rst_oack_i%0d", i), 68'(oack_a[i]), 68'd0);
            chk($sformatf("rst_odist_i%0d", i), odist_a[i], 68'd0);
            chk($sformatf("rst_oindex_i%0d", i), 68'(oindex_a[i]), 68'd0);
            chk($sformatf("rst_obusy_i%0d", i), 68'(obusy_a[i]), 68'd0);
        end

        // Long-held words captured once; result appears two cycles after last capture.
        send_word(0, 64'd4, 3, vc);
        send_word(0, 64'd9, 3, vc);
        send_word(0, 64'd16, 3, vc);
        chk("latency_cycle", 68'(vc), 68'd3);
        finish_result(0, 68'd29, 2'd0, "single");

        // Table of vectors.
        for (int v = 0; v < NV; v++) begin
            k = vecs[v].inst;
            for (int j = 0; j < vecs[v].n; j++) send_word(k, vecs[v].w[j], (j % 3) + 1, vc);
            finish_result(k, vecs[v].exp_dist, vecs[v].exp_idx, $sformatf("vec%0d", v));
        end

        // Backpressure: next word waits during RESULT while iack is withheld.
        for (int j = 0; j < 6; j++) send_word(1, vecs[0].w[j], 1, vc);
        k = 0;
        while (!ovalid_a[1] && k < 40) begin
            @(negedge iclk);
            k++;
        end
        chk("bp_valid", 68'(ovalid_a[1]), 68'd1);
        idata_a[1] = 64'd7;
        ivalid_a[1] = 1'b1;
        cnt_ack = 0;
        cnt_val = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge iclk);
            if (oack_a[1]) cnt_ack++;
            if (ovalid_a[1]) cnt_val++;
        end
        chk("bp_no_ack", 68'(cnt_ack), 68'd0);
        chk("bp_valid_held", 68'(cnt_val), 68'd10);
        iack_a[1] = 1'b1;
        @(negedge iclk);
        iack_a[1] = 1'b0;
        chk("bp_valid_drop", 68'(ovalid_a[1]), 68'd0);
        chk("bp_ack_wait", 68'(oack_a[1]), 68'd0);
        @(negedge iclk);
        chk("bp_captured", 68'(oack_a[1]), 68'd1);
        ivalid_a[1] = 1'b0;
        @(negedge iclk);
        send_word(1, 64'd3, 2, vc);
        send_word(1, 64'd40, 1, vc);
        send_word(1, 64'd0, 1, vc);
        send_word(1, 64'd50, 1, vc);
        send_word(1, 64'd0, 1, vc);
        finish_result(1, 68'd10, 2'd0, "bp_after");

        // Reset mid-template discards the partial sum.
        send_word(0, 64'd100, 1, vc);
        send_word(0, 64'd200, 2, vc);
        chk("prerst_busy", 68'(obusy_a[0]), 68'd1);
        irst_a[0] = 1'b1;
        @(negedge iclk);
        irst_a[0] = 1'b0;
        chk("mrst_odist", odist_a[0], 68'd0);
        chk("mrst_oindex", 68'(oindex_a[0]), 68'd0);
        chk("mrst_ovalid", 68'(ovalid_a[0]), 68'd0);
        chk("mrst_oack", 68'(oack_a[0]), 68'd0);
        chk("mrst_obusy", 68'(obusy_a[0]), 68'd0);
        send_word(0, 64'd5, 1, vc);
        send_word(0, 64'd6, 2, vc);
        send_word(0, 64'd7, 1, vc);
        finish_result(0, 68'd18, 2'd0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
